// File: rtl/vfifo_pkg.sv
// Shared constants and helpers for the vfifo single-clock FIFO family.
// Holds default word width / depth exponent, a clog2 helper and the
// occupancy-counter width formula (one extra bit so DEPTH itself fits).
package vfifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 9;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Level must represent 0..DEPTH inclusive.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/vfifo_sync_fifo_sc_if.sv
// Handshake/status bundle between a producer/consumer and vfifo_sync_fifo_sc.
// master: drives wr_en/wr_data/rd_en, observes data and flags.
// slave : the FIFO, drives rd_data, full/empty, thresholds, level, error pulses.
interface vfifo_sync_fifo_sc_if
    import vfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                               wr_en;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic                               rd_en;
    logic [DATA_WIDTH-1:0]              rd_data;
    logic                               full;
    logic                               empty;
    logic                               almost_full;
    logic                               almost_empty;
    logic [level_width(ADDR_WIDTH)-1:0] level;
    logic                               overflow;
    logic                               underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/vfifo_sdp_ram_sc.sv
// Single-clock simple dual-port RAM, one write port and one registered read port.
// Latency: q updates one clock after re; q holds when re is low.
// Backpressure: none; same-address read/write in one cycle returns old data.
// Ports: clk/rst, we/adr_w/d (write), re/adr_r/q (read). rst clears only q.
module vfifo_sdp_ram_sc #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] adr_w,
    input  logic [DW-1:0] d,
    input  logic          re,
    input  logic [AW-1:0] adr_r,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[adr_w] <= d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (re) q <= mem[adr_r];
    end
endmodule

// File: rtl/vfifo_sync_fifo_sc.sv
// Single-clock FIFO over an SDP RAM with level, full/empty and threshold flags.
// Latency: rd_data valid 1 cycle after accepted rd_en (FWFT: head word shown, empty falls 2 cycles after first write).
// Backpressure: write rejected when full (overflow pulse), read rejected when empty (underflow pulse).
// Ports: clk, rst (async active-high), bus (vfifo_sync_fifo_sc_if.slave).
// Build option: define VFIFO_SC_FWFT_EN for first-word-fall-through mode.
module vfifo_sync_fifo_sc
    import vfifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input logic                   clk,
    input logic                   rst,
    vfifo_sync_fifo_sc_if.slave   bus
);
    localparam int            LW    = level_width(ADDR_WIDTH);
    localparam logic [LW-1:0] DEPTH = LW'(2**ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0]         level_q, lvl_nxt;
    logic                  full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
    logic                  acc_wr, acc_rd, ram_re, empty_nxt;
    logic [DATA_WIDTH-1:0] ram_q, rd_data_w;

    assign acc_wr  = bus.wr_en & ~full_q;
    assign lvl_nxt = level_q + LW'(acc_wr) - LW'(acc_rd);

    vfifo_sdp_ram_sc #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (acc_wr),
        .adr_w (wr_ptr),
        .d     (bus.wr_data),
        .re    (ram_re),
        .adr_r (rd_ptr),
        .q     (ram_q)
    );

`ifdef VFIFO_SC_FWFT_EN
    // Two-stage prefetch: RAM q register (q_vld) then output register (out_vld).
    // level covers both stages, so words still in RAM = level - stages occupied.
    logic                  q_vld, out_vld, q_move, out_vld_nxt;
    logic [DATA_WIDTH-1:0] out_dat;
    logic [LW-1:0]         ram_words;

    assign acc_rd      = bus.rd_en & out_vld;
    assign ram_words   = level_q - LW'(out_vld) - LW'(q_vld);
    assign q_move      = q_vld & (~out_vld | acc_rd);
    // Fetch only when the q stage is free or emptying this edge, so q never gets overwritten.
    assign ram_re      = (ram_words != '0) & (~q_vld | q_move);
    assign out_vld_nxt = q_move | (out_vld & ~acc_rd);
    assign empty_nxt   = ~out_vld_nxt;
    assign rd_data_w   = out_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_vld   <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            q_vld   <= ram_re | (q_vld & ~q_move);
            out_vld <= out_vld_nxt;
            if (q_move) out_dat <= ram_q;
        end
    end
`else
    assign acc_rd    = bus.rd_en & ~empty_q;
    assign ram_re    = acc_rd;
    assign empty_nxt = (lvl_nxt == '0);
    assign rd_data_w = ram_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (acc_wr) wr_ptr <= wr_ptr + 1'b1;
            if (ram_re) rd_ptr <= rd_ptr + 1'b1;
            level_q <= lvl_nxt;
            full_q  <= (lvl_nxt == DEPTH);
            empty_q <= empty_nxt;
            af_q    <= (lvl_nxt >= LW'(AFULL_LEVEL));
            ae_q    <= (lvl_nxt <= LW'(AEMPTY_LEVEL));
            ovf_q   <= bus.wr_en & full_q;
            udf_q   <= bus.rd_en & empty_q;
        end
    end

    assign bus.rd_data      = rd_data_w;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule
